// File: rtl/bird_column.sv
// bird_column: position register for the bird's whole LED column.
// Applies tick-divided gravity and flap lift with ceiling clamping, and detects
// ground hits and pipe collisions against the scroller's obstacle mask.
//
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset
//   KEY0       flap button (synchronised, active-high); rising edge detected here
//   pipeMask   obstacle rows at the bird's x-position, bit i = row i
//   lightOn    one-hot bird row for the display driver (registered)
//   groundOut  one-cycle pulse on ground hit
//   crash      one-cycle pulse on pipe collision
//   dead       high while in DEAD
//   flying     high while in FLY
module bird_column #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned TICK_DIV  = 1792,
    parameter int unsigned FLAP_ROWS = 1,
    parameter int unsigned START_ROW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            KEY0,
    input  logic [ROWS-1:0] pipeMask,
    output logic [ROWS-1:0] lightOn,
    output logic            groundOut,
    output logic            crash,
    output logic            dead,
    output logic            flying
);

    localparam int unsigned PosW = $clog2(ROWS);
    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PosW-1:0] StartPos   = PosW'(START_ROW);
    localparam logic [PosW:0]   TopRow     = (PosW+1)'(ROWS - 1);
    localparam logic [PosW:0]   Lift       = (PosW+1)'(FLAP_ROWS);
    localparam logic [CntW-1:0] CntMax     = CntW'(TICK_DIV - 1);
    localparam logic [ROWS-1:0] StartLight = ROWS'(1) << START_ROW;

    typedef enum logic [1:0] {StIdle, StFly, StDead} state_e;

    state_e            state_q, state_d;
    logic [PosW-1:0]   pos_q, pos_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              key_q;
    logic [ROWS-1:0]   light_q;
    logic              ground_q, ground_d;
    logic              crash_q, crash_d;
    logic              dead_q;
    logic              flying_q;

    logic              tick;
    logic              flap_edge;
    logic              flap;
    logic [PosW:0]     lift_sum;
    logic [PosW-1:0]   lifted;
    logic [PosW-1:0]   next_pos;

    assign tick      = (cnt_q == CntMax);
    assign flap_edge = KEY0 & ~key_q;
    // A flap edge arriving on the tick cycle itself still counts for this tick.
    assign flap      = pend_q | flap_edge;

    // One bit wider than pos so the lift can never wrap before clamping.
    assign lift_sum  = {1'b0, pos_q} + Lift;
    assign lifted    = (lift_sum > TopRow) ? TopRow[PosW-1:0] : lift_sum[PosW-1:0];

    assign cnt_d     = tick ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        pend_d   = pend_q;
        ground_d = 1'b0;
        crash_d  = 1'b0;
        next_pos = pos_q;

        if (tick) begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                pos_d = StartPos;
                if (flap_edge) begin
                    state_d = StFly;
                end
            end
            StFly: begin
                if (flap_edge && !tick) begin
                    pend_d = 1'b1;
                end
                if (tick) begin
                    if (flap) begin
                        next_pos = lifted;
                    end else if (pos_q != '0) begin
                        next_pos = pos_q - 1'b1;
                    end
                    pos_d = next_pos;
                    // Crash wins over a simultaneous ground hit.
                    if (pipeMask[next_pos]) begin
                        crash_d = 1'b1;
                        state_d = StDead;
                    end else if (!flap && pos_q == '0) begin
                        ground_d = 1'b1;
                        state_d  = StDead;
                    end
                end else if (pipeMask[pos_q]) begin
                    // Pipe scrolled onto the bird between ticks.
                    crash_d = 1'b1;
                    state_d = StDead;
                end
            end
            StDead: begin
                if (flap_edge) begin
                    state_d = StIdle;
                    pos_d   = StartPos;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                pos_d   = StartPos;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            pos_q    <= StartPos;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            key_q    <= 1'b0;
            light_q  <= StartLight;
            ground_q <= 1'b0;
            crash_q  <= 1'b0;
            dead_q   <= 1'b0;
            flying_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            key_q    <= KEY0;
            light_q  <= ROWS'(1) << pos_d;
            ground_q <= ground_d;
            crash_q  <= crash_d;
            dead_q   <= (state_d == StDead);
            flying_q <= (state_d == StFly);
        end
    end

    assign lightOn   = light_q;
    assign groundOut = ground_q;
    assign crash     = crash_q;
    assign dead      = dead_q;
    assign flying    = flying_q;

endmodule
